// File: rtl/key_bank_crypto_frontend.sv
// Register-mapped front end for a block cipher core: lockable register file, key slots,
// and an IDLE/LOAD/RUN launcher with a RUN-cycle watchdog.
module key_bank_crypto_frontend #(
    parameter int NUM_KEYS  = 4,
    parameter int KEY_WIDTH = 192,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [7:0]           reglk_ctrl_i,
    input  logic [31:0]          reg_addr_i,
    input  logic                 reg_write_i,
    input  logic [31:0]          reg_wdata_i,
    output logic [31:0]          reg_rdata_o,
    output logic                 reg_ready_o,
    output logic                 reg_error_o,
    output logic                 core_start_o,
    output logic [KEY_WIDTH-1:0] core_key_o,
    output logic [127:0]         core_pt_o,
    output logic [127:0]         core_state_o,
    input  logic [127:0]         core_ct_i,
    input  logic                 core_valid_i,
    output logic                 irq_o
);
    localparam int KW = KEY_WIDTH / 32;
    localparam int SW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [7:0]    KEY_END  = 8'(8 * NUM_KEYS);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

    state_e               fsm_q;
    logic [CW-1:0]        cnt_q;
    logic                 start_q;
    logic [KEY_WIDTH-1:0] key_out_q;
    logic [127:0]         pt_out_q;
    logic [127:0]         st_out_q;
    logic [127:0]         ct_q;
    logic [KEY_WIDTH-1:0] slot_q [NUM_KEYS];
    logic [31:0]          pt_q [4];
    logic [31:0]          st_q [4];
    logic [31:0]          key_sel_q;
    logic                 done_q, err_to_q, err_acc_q;
    logic                 done_d, err_to_d, err_acc_d;

    logic [7:0]    idx, rel;
    logic          busy, sel_ok, is_key, is_pt, is_st, is_ct;
    logic [SW-1:0] sel, key_k;
    logic [2:0]    key_j;
    logic          pt_we, st_we, ksel_we, key_we, start_acc, clear_acc;
    logic [2:0]    w1c;
    logic          hw_done, hw_to;
    logic          unused_addr;

    assign idx    = reg_addr_i[9:2];
    assign rel    = idx - 8'd16;
    assign busy   = (fsm_q != IDLE);
    assign sel_ok = (key_sel_q < 32'(NUM_KEYS));
    assign sel    = key_sel_q[SW-1:0];
    assign key_k  = rel[3 +: SW];
    assign key_j  = rel[2:0];
    assign is_key = (idx >= 8'd16) && (rel < KEY_END) && ({1'b0, key_j} < 4'(KW));
    assign is_pt  = (idx[7:2] == 6'd1);
    assign is_st  = (idx[7:2] == 6'd2);
    assign is_ct  = (idx[7:2] == 6'd3);

    assign unused_addr = ^{reg_addr_i[31:10], reg_addr_i[1:0]};

    assign reg_ready_o  = 1'b1;
    assign core_start_o = start_q;
    assign core_key_o   = key_out_q;
    assign core_pt_o    = pt_out_q;
    assign core_state_o = st_out_q;
    assign irq_o        = done_q | err_to_q | err_acc_q;

    // Write decode: every rejected write (lock, busy, bad slot select) raises the error pulse.
    always_comb begin
        reg_error_o = 1'b0;
        pt_we       = 1'b0;
        st_we       = 1'b0;
        ksel_we     = 1'b0;
        key_we      = 1'b0;
        start_acc   = 1'b0;
        clear_acc   = 1'b0;
        w1c         = 3'b000;
        if (reg_write_i) begin
            if (idx == 8'd0) begin
                if (reglk_ctrl_i[1] || busy) begin
                    reg_error_o = 1'b1;
                end else if (reg_wdata_i[1]) begin
                    if (reglk_ctrl_i[5] || !sel_ok) reg_error_o = 1'b1;
                    else                            clear_acc   = 1'b1;
                end else if (reg_wdata_i[0]) begin
                    if (!sel_ok) reg_error_o = 1'b1;
                    else         start_acc   = 1'b1;
                end
            end else if (idx == 8'd1) begin
                w1c = reg_wdata_i[3:1];
            end else if (idx == 8'd2) begin
                if (reglk_ctrl_i[1] || busy) reg_error_o = 1'b1;
                else                         ksel_we     = 1'b1;
            end else if (is_pt) begin
                if (reglk_ctrl_i[3] || busy) reg_error_o = 1'b1;
                else                         pt_we       = 1'b1;
            end else if (is_st) begin
                if (reglk_ctrl_i[7] || busy) reg_error_o = 1'b1;
                else                         st_we       = 1'b1;
            end else if (is_key) begin
                if (reglk_ctrl_i[5] || busy) reg_error_o = 1'b1;
                else                         key_we      = 1'b1;
            end
        end
    end

    assign hw_done = (fsm_q == RUN) && core_valid_i;
    assign hw_to   = (fsm_q == RUN) && !core_valid_i && (cnt_q == CNT_LAST);

    // Hardware sets are OR-ed in after the clear so a same-cycle W1C cannot lose an event.
    always_comb begin
        done_d    = (done_q & ~w1c[0]) | hw_done;
        err_to_d  = (err_to_q & ~w1c[1]) | hw_to;
        err_acc_d = (err_acc_q & ~w1c[2]) | reg_error_o;
        if (start_acc) done_d = 1'b0;
    end

    always_comb begin
        reg_rdata_o = 32'd0;
        if (idx == 8'd1) begin
            if (!reglk_ctrl_i[6]) reg_rdata_o = {28'd0, err_acc_q, err_to_q, done_q, busy};
        end else if (idx == 8'd2) begin
            if (!reglk_ctrl_i[0]) reg_rdata_o = key_sel_q;
        end else if (is_pt) begin
            if (!reglk_ctrl_i[2]) reg_rdata_o = pt_q[idx[1:0]];
        end else if (is_st) begin
            reg_rdata_o = st_q[idx[1:0]];
        end else if (is_ct) begin
            if (!reglk_ctrl_i[4]) reg_rdata_o = ct_q[{idx[1:0], 5'd0} +: 32];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_KEYS; k++) slot_q[k] <= '0;
            for (int i = 0; i < 4; i++) begin
                pt_q[i] <= 32'd0;
                st_q[i] <= 32'd0;
            end
            key_sel_q <= 32'd0;
            done_q    <= 1'b0;
            err_to_q  <= 1'b0;
            err_acc_q <= 1'b0;
        end else begin
            done_q    <= done_d;
            err_to_q  <= err_to_d;
            err_acc_q <= err_acc_d;
            if (ksel_we) key_sel_q <= reg_wdata_i;
            if (pt_we)   pt_q[idx[1:0]] <= reg_wdata_i;
            if (st_we)   st_q[idx[1:0]] <= reg_wdata_i;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (clear_acc && sel == SW'(k)) slot_q[k] <= '0;
                for (int j = 0; j < KW; j++) begin
                    if (key_we && key_k == SW'(k) && key_j == 3'(j))
                        slot_q[k][32*j +: 32] <= reg_wdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q     <= IDLE;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            key_out_q <= '0;
            pt_out_q  <= '0;
            st_out_q  <= '0;
            ct_q      <= '0;
        end else begin
            start_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start_acc) begin
                        key_out_q <= slot_q[sel];
                        pt_out_q  <= {pt_q[3], pt_q[2], pt_q[1], pt_q[0]};
                        st_out_q  <= {st_q[3], st_q[2], st_q[1], st_q[0]};
                        start_q   <= 1'b1;
                        fsm_q     <= LOAD;
                    end
                end
                LOAD: begin
                    cnt_q <= '0;
                    fsm_q <= RUN;
                end
                RUN: begin
                    if (core_valid_i) begin
                        ct_q  <= core_ct_i;
                        fsm_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        fsm_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule
